// File: rtl/reaction_ctrl.sv
// Round sequencer for the reaction-time game: random pre-LED delay, reaction capture,
// false-start/timeout flags, best-time tracking and round counting. All outputs registered.
module reaction_ctrl #(
  parameter logic [10:0] WAIT_MIN = 11'd1000,
  parameter logic [11:0] TIMEOUT  = 12'h999
) (
  input  logic        clk,
  input  logic        ar,
  input  logic        btn,
  input  logic        tick,
  input  logic [11:0] count_in,
  output logic        led,
  output logic        ctr_en,
  output logic        ctr_clr,
  output logic [11:0] result,
  output logic [11:0] best,
  output logic        best_valid,
  output logic        false_start,
  output logic        timeout,
  output logic [7:0]  rounds,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_GO    = 3'd2,
    S_DONE  = 3'd3,
    S_FALSE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        btn_q;
  logic [9:0]  lfsr_q, lfsr_d;
  logic [10:0] wait_cnt_q, wait_cnt_d;
  logic        led_q, led_d;
  logic        ctr_en_q, ctr_en_d;
  logic        ctr_clr_q, ctr_clr_d;
  logic [11:0] result_q, result_d;
  logic [11:0] best_q, best_d;
  logic        best_valid_q, best_valid_d;
  logic        false_start_q, false_start_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  rounds_q, rounds_d;

  logic        press;
  logic        start_round;
  logic        round_end;

  assign press = btn & ~btn_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    lfsr_d        = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    wait_cnt_d    = wait_cnt_q;
    ctr_clr_d     = 1'b0;
    result_d      = result_q;
    best_d        = best_q;
    best_valid_d  = best_valid_q;
    false_start_d = false_start_q;
    timeout_d     = timeout_q;
    rounds_d      = rounds_q;
    start_round   = 1'b0;
    round_end     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_FALSE: begin
        if (press) begin
          start_round = 1'b1;
        end else begin
          start_round = 1'b0;
        end
      end
      S_WAIT: begin
        // An early press beats a same-cycle expiry
        if (press) begin
          state_d       = S_FALSE;
          false_start_d = 1'b1;
          round_end     = 1'b1;
        end else if (tick) begin
          if (wait_cnt_q == 11'd0) begin
            state_d = S_GO;
          end else begin
            wait_cnt_d = wait_cnt_q - 11'd1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
      end
      S_GO: begin
        if (press) begin
          state_d   = S_DONE;
          result_d  = count_in;
          timeout_d = 1'b0;
          round_end = 1'b1;
          if (!best_valid_q || (count_in < best_q)) begin
            best_d       = count_in;
            best_valid_d = 1'b1;
          end else begin
            best_d = best_q;
          end
        end else if (count_in == TIMEOUT) begin
          state_d   = S_DONE;
          result_d  = TIMEOUT;
          timeout_d = 1'b1;
          round_end = 1'b1;
        end else begin
          state_d = S_GO;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_round) begin
      state_d       = S_WAIT;
      ctr_clr_d     = 1'b1;
      wait_cnt_d    = WAIT_MIN + {1'b0, lfsr_q};
      false_start_d = 1'b0;
      timeout_d     = 1'b0;
    end else begin
      ctr_clr_d = 1'b0;
    end

    if (round_end && (rounds_q != 8'hFF)) begin
      rounds_d = rounds_q + 8'd1;
    end else begin
      rounds_d = rounds_q;
    end

    led_d    = (state_d == S_GO);
    ctr_en_d = (state_d == S_GO);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (ar) begin
      state_q       <= S_IDLE;
      btn_q         <= 1'b1;
      lfsr_q        <= 10'h001;
      wait_cnt_q    <= 11'd0;
      led_q         <= 1'b0;
      ctr_en_q      <= 1'b0;
      ctr_clr_q     <= 1'b0;
      result_q      <= 12'h000;
      best_q        <= 12'h999;
      best_valid_q  <= 1'b0;
      false_start_q <= 1'b0;
      timeout_q     <= 1'b0;
      rounds_q      <= 8'd0;
    end else begin
      state_q       <= state_d;
      btn_q         <= btn;
      lfsr_q        <= lfsr_d;
      wait_cnt_q    <= wait_cnt_d;
      led_q         <= led_d;
      ctr_en_q      <= ctr_en_d;
      ctr_clr_q     <= ctr_clr_d;
      result_q      <= result_d;
      best_q        <= best_d;
      best_valid_q  <= best_valid_d;
      false_start_q <= false_start_d;
      timeout_q     <= timeout_d;
      rounds_q      <= rounds_d;
    end
  end

  assign led         = led_q;
  assign ctr_en      = ctr_en_q;
  assign ctr_clr     = ctr_clr_q;
  assign result      = result_q;
  assign best        = best_q;
  assign best_valid  = best_valid_q;
  assign false_start = false_start_q;
  assign timeout     = timeout_q;
  assign rounds      = rounds_q;
  assign state       = state_q;

endmodule
